// File: rtl/dadda_8b_inv_div.sv
// rtl/dadda_8b_inv_div.sv - sequential unsigned restoring divider, inverse of the 8x8 Dadda multiplier.
// Define APPROX_DIV_TRUNC_EN to zero the TRUNC dividend LSBs at accept (truncated-multiplier match).
module dadda_8b_inv_div #(
  parameter int WIDTH_N = 16,
  parameter int WIDTH_D = 8,
  parameter int TRUNC   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_N-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder,
  output logic               div_by_zero
);

  localparam int CNT_W = (WIDTH_N > 1) ? $clog2(WIDTH_N) : 1;

`ifdef APPROX_DIV_TRUNC_EN
  localparam int TRUNC_EN = 1;
`else
  localparam int TRUNC_EN = 0;
`endif

  localparam int TRUNC_BITS = TRUNC_EN * TRUNC;
  localparam logic [WIDTH_N-1:0] DVD_MASK =
    ~((WIDTH_N'(1) << TRUNC_BITS) - WIDTH_N'(1));

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [WIDTH_N-1:0] r_q;
  logic [WIDTH_D-1:0] r_rem;
  logic [WIDTH_D-1:0] r_div;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH_N-1:0] r_quotient;
  logic [WIDTH_D-1:0] r_remainder;
  logic               r_dbz;

  logic [WIDTH_N-1:0] w_dividend_eff;
  logic               w_accept;
  logic               w_consume;
  logic [WIDTH_D:0]   w_t;
  logic               w_ge;
  logic [WIDTH_D-1:0] w_rem_next;
  logic [WIDTH_N-1:0] w_q_next;

  assign w_dividend_eff = dividend & DVD_MASK;
  assign w_accept       = in_valid && (r_state == S_IDLE);
  assign w_consume      = out_ready && (r_state == S_DONE);

  // Partial remainder stays below the divisor, so only the trial value needs the extra bit.
  assign w_t        = {r_rem, r_q[WIDTH_N-1]};
  assign w_ge       = (w_t >= {1'b0, r_div});
  assign w_rem_next = w_ge ? WIDTH_D'(w_t - {1'b0, r_div}) : w_t[WIDTH_D-1:0];
  assign w_q_next   = {r_q[WIDTH_N-2:0], w_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_q         <= '0;
      r_rem       <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_q   <= w_dividend_eff;
            r_div <= divisor;
            r_rem <= '0;
            r_cnt <= CNT_W'(WIDTH_N - 1);
            if (divisor == '0) begin
              r_state     <= S_DONE;
              r_quotient  <= '1;
              r_remainder <= w_dividend_eff[WIDTH_D-1:0];
              r_dbz       <= 1'b1;
            end else begin
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          r_q   <= w_q_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) begin
            r_state     <= S_DONE;
            r_quotient  <= w_q_next;
            r_remainder <= w_rem_next;
            r_dbz       <= 1'b0;
          end
        end
        S_DONE: begin
          if (w_consume) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule
